// File: rtl/mac_result_drain.sv
// mac_result_drain: consumer end of the shared MAC bank.
// Captures one vector of LANES signed accumulators plus per-lane biases in a single
// handshake, then streams one post-processed word per lane to a feature buffer write port.
// Per-lane processing: bias add, round-half-up arithmetic shift, optional ReLU, saturation.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_cap_valid/o_cap_ready  capture handshake for i_mac_in, i_bias_in, i_base_addr, i_relu_en
//   i_mac_in              LANES x ACC_W signed accumulators, lane k at [k*ACC_W +: ACC_W]
//   i_bias_in             LANES x BIAS_W signed biases, lane k at [k*BIAS_W +: BIAS_W]
//   i_base_addr           write address of lane 0 (lanes wrap modulo 2^ADDR_W)
//   i_relu_en             clamp negative results to zero
//   o_out_valid/i_out_ready  write handshake for o_out_addr/o_out_data
//   o_busy                vector held and not fully drained
//   o_done                one-cycle pulse after the last lane is accepted
module mac_result_drain #(
  parameter int unsigned LANES  = 6,
  parameter int unsigned ACC_W  = 23,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 7,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cap_valid,
  output logic                      o_cap_ready,
  input  logic [LANES*ACC_W-1:0]    i_mac_in,
  input  logic [LANES*BIAS_W-1:0]   i_bias_in,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic                      i_relu_en,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [ADDR_W-1:0]         o_out_addr,
  output logic [OUT_W-1:0]          o_out_data,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  // Two guard bits: acc + bias + rounding constant can never overflow.
  localparam int unsigned SumW  = ACC_W + 2;
  localparam int unsigned RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [SumW-1:0] Round  = SumW'(SHIFT > 0) << RndSh;
  localparam logic signed [SumW-1:0] SatMax = {{(SumW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e                  r_state, w_state_nxt;
  logic [LaneW-1:0]        r_lane, w_lane_nxt;
  logic                    r_out_valid, w_valid_nxt;
  logic [ADDR_W-1:0]       r_out_addr, w_addr_nxt;
  logic [OUT_W-1:0]        r_out_data, w_data_nxt;
  logic                    r_done, w_done_nxt;

  // Captured copy of the vector; inputs are free to change once it is taken.
  logic [LANES*ACC_W-1:0]  r_mac;
  logic [LANES*BIAS_W-1:0] r_bias;
  logic [ADDR_W-1:0]       r_base;
  logic                    r_relu;

  logic                    w_cap;
  logic                    w_last;
  logic [LaneW-1:0]        w_sel_lane;
  logic [ACC_W-1:0]        w_acc_sel;
  logic [BIAS_W-1:0]       w_bias_sel;
  logic                    w_relu_sel;
  logic signed [SumW-1:0]  w_acc_ext, w_bias_ext, w_sum, w_shr;
  logic [OUT_W-1:0]        w_res;

  assign w_cap      = (r_state == StIdle) && i_cap_valid;
  assign w_last     = (r_lane == LaneW'(LANES - 1));
  // Lane whose result is loaded into the output register next; clamped so the
  // part-select never leaves the vector.
  assign w_sel_lane = w_last ? r_lane : r_lane + LaneW'(1);

  // One shared post-processing unit: on capture it works straight from the inputs so
  // lane 0 is presented the very next cycle; afterwards it works from the captured copy.
  always_comb begin
    if (w_cap) begin
      w_acc_sel  = i_mac_in[0 +: ACC_W];
      w_bias_sel = i_bias_in[0 +: BIAS_W];
      w_relu_sel = i_relu_en;
    end else begin
      w_acc_sel  = r_mac[w_sel_lane*ACC_W +: ACC_W];
      w_bias_sel = r_bias[w_sel_lane*BIAS_W +: BIAS_W];
      w_relu_sel = r_relu;
    end
  end

  assign w_acc_ext  = {{2{w_acc_sel[ACC_W-1]}}, w_acc_sel};
  assign w_bias_ext = {{(SumW-BIAS_W){w_bias_sel[BIAS_W-1]}}, w_bias_sel};
  assign w_sum      = w_acc_ext + w_bias_ext + Round;
  assign w_shr      = w_sum >>> SHIFT;

  always_comb begin
    w_res = w_shr[OUT_W-1:0];
    if (w_relu_sel && w_shr[SumW-1]) begin
      w_res = '0;
    end else if (w_shr > SatMax) begin
      w_res = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shr < SatMin) begin
      w_res = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_valid_nxt = r_out_valid;
    w_addr_nxt  = r_out_addr;
    w_data_nxt  = r_out_data;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cap_valid) begin
          w_state_nxt = StDrain;
          w_lane_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = i_base_addr;
          w_data_nxt  = w_res;
        end
      end
      StDrain: begin
        if (i_out_ready) begin
          if (w_last) begin
            w_state_nxt = StIdle;
            w_lane_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_lane_nxt  = w_sel_lane;
            w_addr_nxt  = r_base + ADDR_W'(w_sel_lane);
            w_data_nxt  = w_res;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_lane      <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_addr  <= w_addr_nxt;
      r_out_data  <= w_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mac  <= '0;
      r_bias <= '0;
      r_base <= '0;
      r_relu <= 1'b0;
    end else if (w_cap) begin
      r_mac  <= i_mac_in;
      r_bias <= i_bias_in;
      r_base <= i_base_addr;
      r_relu <= i_relu_en;
    end
  end

  assign o_cap_ready = (r_state == StIdle);
  assign o_busy      = (r_state == StDrain);
  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_done      = r_done;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed cases plus randomized vectors,
// each checked word-by-word against a plain-arithmetic reference model.
module tb_mac_result_drain;

  localparam int LANES  = 6;
  localparam int ACC_W  = 23;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 7;
  localparam int ADDR_W = 10;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_cap_valid;
  logic                    o_cap_ready;
  logic [LANES*ACC_W-1:0]  i_mac_in;
  logic [LANES*BIAS_W-1:0] i_bias_in;
  logic [ADDR_W-1:0]       i_base_addr;
  logic                    i_relu_en;
  logic                    o_out_valid;
  logic                    i_out_ready;
  logic [ADDR_W-1:0]       o_out_addr;
  logic [OUT_W-1:0]        o_out_data;
  logic                    o_busy;
  logic                    o_done;

  int n_checks = 0;
  int n_pass   = 0;
  int v_acc  [LANES];
  int v_bias [LANES];

  mac_result_drain #(
    .LANES  (LANES),
    .ACC_W  (ACC_W),
    .BIAS_W (BIAS_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cap_valid (i_cap_valid),
    .o_cap_ready (o_cap_ready),
    .i_mac_in    (i_mac_in),
    .i_bias_in   (i_bias_in),
    .i_base_addr (i_base_addr),
    .i_relu_en   (i_relu_en),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_addr  (o_out_addr),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: exact integer arithmetic with floor division for the rescale.
  function automatic longint ref_word(longint acc, longint bias, bit relu);
    longint den, s, r;
    den = longint'(1) << SHIFT;
    s   = acc + bias + ((SHIFT > 0) ? den / 2 : 0);
    if (s >= 0) r = s / den;
    else        r = -((-s + den - 1) / den);
    if (relu && r < 0) r = 0;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic drive_vector();
    for (int k = 0; k < LANES; k++) begin
      i_mac_in[k*ACC_W +: ACC_W]    = v_acc[k][ACC_W-1:0];
      i_bias_in[k*BIAS_W +: BIAS_W] = v_bias[k][BIAS_W-1:0];
    end
  endtask

  task automatic randomize_vector();
    for (int k = 0; k < LANES; k++) begin
      if ($urandom_range(0, 1) == 1) v_acc[k] = $signed($urandom) >>> (32 - ACC_W);
      else                           v_acc[k] = $signed($urandom) >>> 17;
      v_bias[k] = $signed($urandom) >>> (32 - BIAS_W);
    end
  endtask

  // Garbage on the capture inputs while draining; none of it may be sampled.
  task automatic drive_noise();
    i_cap_valid = 1'($urandom_range(0, 1));
    for (int k = 0; k < LANES; k++) begin
      i_mac_in[k*ACC_W +: ACC_W]    = ACC_W'($urandom);
      i_bias_in[k*BIAS_W +: BIAS_W] = BIAS_W'($urandom);
    end
    i_base_addr = ADDR_W'($urandom);
    i_relu_en   = 1'($urandom_range(0, 1));
  endtask

  // Starts at a negedge with the block idle; captures v_acc/v_bias, drains all lanes and
  // ends on the done-cycle negedge (b2b=1) or one cycle later (b2b=0).
  // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_vector(input int base, input bit relu, input int rmode, input bit noise,
                            input bit b2b);
    longint exp_d [LANES];
    int     exp_a [LANES];
    int     idx;
    int     cyc;
    bit     rdy;
    for (int k = 0; k < LANES; k++) begin
      exp_d[k] = ref_word(v_acc[k], v_bias[k], relu);
      exp_a[k] = (base + k) % (1 << ADDR_W);
    end
    check_val("cap_ready_idle", o_cap_ready, 1);
    i_cap_valid = 1'b1;
    drive_vector();
    i_base_addr = ADDR_W'(base);
    i_relu_en   = relu;
    i_out_ready = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    check_val("first_valid", o_out_valid, 1);
    idx = 0;
    cyc = 0;
    while (idx < LANES && cyc < 200) begin
      check_val("valid", o_out_valid, 1);
      check_val("busy", o_busy, 1);
      check_val("cap_ready_drain", o_cap_ready, 0);
      check_val("done_early", o_done, 0);
      check_val($sformatf("addr_lane%0d", idx), o_out_addr, exp_a[idx]);
      check_val($sformatf("data_lane%0d", idx), longint'($signed(o_out_data)), exp_d[idx]);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_out_ready = rdy;
      if (noise) drive_noise();
      else       i_cap_valid = 1'b0;
      @(negedge i_clk);
      if (rdy) idx++;
      cyc++;
    end
    if (idx < LANES) check_val("drain_timeout", idx, LANES);
    i_cap_valid = 1'b0;
    i_out_ready = 1'($urandom_range(0, 1));
    check_val("done_pulse", o_done, 1);
    check_val("valid_after_last", o_out_valid, 0);
    check_val("busy_after_last", o_busy, 0);
    check_val("cap_ready_done", o_cap_ready, 1);
    if (!b2b) begin
      @(negedge i_clk);
      check_val("done_single", o_done, 0);
      check_val("valid_idle", o_out_valid, 0);
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_cap_valid = 1'b0;
    i_mac_in    = '0;
    i_bias_in   = '0;
    i_base_addr = '0;
    i_relu_en   = 1'b0;
    i_out_ready = 1'b0;
    #3;
    check_val("rst_cap_ready", o_cap_ready, 1);
    check_val("rst_out_valid", o_out_valid, 0);
    check_val("rst_out_addr", o_out_addr, 0);
    check_val("rst_out_data", o_out_data, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Basic drain.
    v_acc  = '{12800, 192, 0, 128, -64, 256};
    v_bias = '{0, 0, 0, 0, 0, 0};
    run_vector(40, 1'b0, 0, 1'b0, 1'b0);

    // ReLU and negative rounding, both polarities.
    randomize_vector();
    v_acc[0] = -1000; v_bias[0] = 0;
    v_acc[1] = 100;   v_bias[1] = -200;
    run_vector(100, 1'b1, 0, 1'b0, 1'b0);
    run_vector(200, 1'b0, 0, 1'b0, 1'b0);

    // Saturation at both rails.
    randomize_vector();
    v_acc[0] = 4194303;  v_bias[0] = 32767;
    v_acc[1] = -4194304; v_bias[1] = -32768;
    run_vector(300, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure with capture-side noise during the drain.
    randomize_vector();
    run_vector(500, 1'b0, 1, 1'b1, 1'b0);

    // Address wrap, then a capture on the done cycle.
    randomize_vector();
    run_vector(1022, 1'b0, 0, 1'b0, 1'b1);
    randomize_vector();
    run_vector(7, 1'b1, 0, 1'b0, 1'b0);

    // Reset after two words accepted.
    randomize_vector();
    i_cap_valid = 1'b1;
    drive_vector();
    i_base_addr = 10'd600;
    i_relu_en   = 1'b0;
    @(negedge i_clk);
    i_cap_valid = 1'b0;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check_val("pre_rst_busy", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check_val("midrst_valid", o_out_valid, 0);
    check_val("midrst_busy", o_busy, 0);
    check_val("midrst_done", o_done, 0);
    check_val("midrst_cap_ready", o_cap_ready, 1);
    check_val("midrst_addr", o_out_addr, 0);
    check_val("midrst_data", o_out_data, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_val("postrst_done", o_done, 0);
      check_val("postrst_valid", o_out_valid, 0);
    end
    randomize_vector();
    run_vector(600, 1'b0, 0, 1'b0, 1'b0);

    // Randomized vectors with mixed readiness, noise and back-to-back captures.
    for (int v = 0; v < 24; v++) begin
      randomize_vector();
      run_vector(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 (v < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
